// File: rtl/instruction_fetcher.sv
// Fetch stage: serves scheduler fetch requests from a direct-mapped I-cache, filling misses from program memory.
// Hit: instruction_ready two cycles after fetch_enable; miss: one cycle after mem_read_ready. One request outstanding.
module instruction_fetcher #(
    parameter int PROGRAM_ADDR_BITS = 8,
    parameter int PROGRAM_DATA_BITS = 16,
    parameter int CACHE_ENTRIES     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_enable,
    input  logic [PROGRAM_ADDR_BITS-1:0] pc,
    input  logic                         cache_flush,
    output logic [PROGRAM_DATA_BITS-1:0] instruction,
    output logic                         instruction_ready,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data
);
    localparam int IDX_BITS = $clog2(CACHE_ENTRIES);
    localparam int TAG_BITS = PROGRAM_ADDR_BITS - IDX_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_WAIT, ST_READY} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [PROGRAM_ADDR_BITS-1:0]   r_req_pc;
    logic [PROGRAM_DATA_BITS-1:0]   r_instruction;
    logic                           r_mem_valid;
    logic [PROGRAM_ADDR_BITS-1:0]   r_mem_addr;
    logic [CACHE_ENTRIES-1:0]       r_line_vld;
    logic [TAG_BITS-1:0]            r_line_tag [CACHE_ENTRIES];
    logic [PROGRAM_DATA_BITS-1:0]   r_line_dat [CACHE_ENTRIES];

    logic [IDX_BITS-1:0]            w_idx;
    logic [TAG_BITS-1:0]            w_tag;
    logic                           w_same_req;
    logic                           w_hit;
    logic                           w_latch;
    logic                           w_issue;
    logic                           w_fill;
    logic                           w_load_instr;
    logic [PROGRAM_DATA_BITS-1:0]   w_instr_nxt;

    assign w_idx      = r_req_pc[IDX_BITS-1:0];
    assign w_tag      = r_req_pc[PROGRAM_ADDR_BITS-1:IDX_BITS];
    // A changed pc means the scheduler moved to another warp; the old request is dropped.
    assign w_same_req = fetch_enable && (pc == r_req_pc);
    assign w_hit      = r_line_vld[w_idx] && (r_line_tag[w_idx] == w_tag);

    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_issue      = 1'b0;
        w_fill       = 1'b0;
        w_load_instr = 1'b0;
        w_instr_nxt  = r_instruction;
        case (r_state)
            ST_IDLE: begin
                if (fetch_enable) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!w_same_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hit) begin
                    w_load_instr = 1'b1;
                    w_instr_nxt  = r_line_dat[w_idx];
                    w_state_nxt  = ST_READY;
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_read_ready) begin
                    w_fill = 1'b1;
                    if (w_same_req) begin
                        w_load_instr = 1'b1;
                        w_instr_nxt  = mem_read_data;
                        w_state_nxt  = ST_READY;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_READY: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_req_pc      <= '0;
            r_instruction <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_req_pc <= pc;
            end
            if (w_load_instr) begin
                r_instruction <= w_instr_nxt;
            end
            if (w_issue) begin
                r_mem_valid <= 1'b1;
                r_mem_addr  <= r_req_pc;
            end else if (w_fill) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    // Flush beats a coincident fill; the fill's data is still forwarded by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_vld <= '0;
        end else if (cache_flush) begin
            r_line_vld <= '0;
        end else if (w_fill) begin
            r_line_vld[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_line_tag[w_idx] <= w_tag;
            r_line_dat[w_idx] <= mem_read_data;
        end
    end

    assign instruction       = r_instruction;
    assign instruction_ready = (r_state == ST_READY);
    assign mem_read_valid    = r_mem_valid;
    assign mem_read_address  = r_mem_addr;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized bench for instruction_fetcher against a transaction-level cache model.
module tb_instruction_fetcher;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NE = 4;

    logic          clk;
    logic          reset;
    logic          fetch_enable;
    logic [AW-1:0] pc;
    logic          cache_flush;
    logic [DW-1:0] instruction;
    logic          instruction_ready;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;

    instruction_fetcher #(
        .PROGRAM_ADDR_BITS(AW),
        .PROGRAM_DATA_BITS(DW),
        .CACHE_ENTRIES(NE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_enable(fetch_enable),
        .pc(pc),
        .cache_flush(cache_flush),
        .instruction(instruction),
        .instruction_ready(instruction_ready),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_vec;
    int            n_err;
    logic [DW-1:0] prog [256];
    bit            m_valid [NE];
    logic [AW-1:0] m_pc [NE];
    logic [DW-1:0] m_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle_cycle(input bit stray, input bit flush);
        mem_read_ready = stray;
        mem_read_data  = 16'($urandom);
        cache_flush    = flush;
        @(negedge clk);
        mem_read_ready = 1'b0;
        cache_flush    = 1'b0;
        chk("idle_rdy", 32'(instruction_ready), 0);
        chk("idle_mv", 32'(mem_read_valid), 0);
        if (flush) model_flush();
    endtask

    // mode: 0 plain, 1 flush with fill, 2 flush during lookup, 3 pc switch in WAIT, 4 pc switch in LOOKUP
    task automatic fetch(input logic [AW-1:0] p, input int dly, input int mode);
        int idx;
        bit hit;
        idx = int'(p) % NE;
        hit = m_valid[idx] && (m_pc[idx] == p);
        fetch_enable = 1'b1;
        pc = p;
        @(negedge clk);
        chk("lk_rdy", 32'(instruction_ready), 0);
        chk("lk_mv", 32'(mem_read_valid), 0);
        chk("hold_instr", 32'(instruction), 32'(m_instr));
        if (mode == 4) begin
            pc = p ^ 8'h15;
            @(negedge clk);
            fetch_enable = 1'b0;
            chk("sw_lk_rdy", 32'(instruction_ready), 0);
            chk("sw_lk_mv", 32'(mem_read_valid), 0);
            @(negedge clk);
            return;
        end
        if (mode == 2) cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        if (mode == 2) model_flush();
        if (hit) begin
            chk("hit_rdy", 32'(instruction_ready), 1);
            chk("hit_instr", 32'(instruction), 32'(prog[p]));
            chk("hit_mv", 32'(mem_read_valid), 0);
            m_instr = prog[p];
        end else begin
            chk("req_mv", 32'(mem_read_valid), 1);
            chk("req_addr", 32'(mem_read_address), 32'(p));
            chk("req_rdy", 32'(instruction_ready), 0);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("wait_mv", 32'(mem_read_valid), 1);
                chk("wait_addr", 32'(mem_read_address), 32'(p));
                chk("wait_rdy", 32'(instruction_ready), 0);
            end
            mem_read_ready = 1'b1;
            mem_read_data  = prog[p];
            if (mode == 1) cache_flush = 1'b1;
            if (mode == 3) pc = p ^ 8'h15;
            @(negedge clk);
            mem_read_ready = 1'b0;
            mem_read_data  = 16'($urandom);
            cache_flush    = 1'b0;
            chk("fill_mv", 32'(mem_read_valid), 0);
            if (mode == 3) begin
                chk("sw_rdy", 32'(instruction_ready), 0);
                chk("sw_instr", 32'(instruction), 32'(m_instr));
            end else begin
                chk("miss_rdy", 32'(instruction_ready), 1);
                chk("miss_instr", 32'(instruction), 32'(prog[p]));
                m_instr = prog[p];
            end
            if (mode == 1) begin
                model_flush();
            end else begin
                m_valid[idx] = 1'b1;
                m_pc[idx]    = p;
            end
        end
        fetch_enable = 1'b0;
        @(negedge clk);
        chk("post_rdy", 32'(instruction_ready), 0);
        chk("post_mv", 32'(mem_read_valid), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_instr = '0;
        model_flush();
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        prog[8'h05] = 16'h3A7F;
        reset = 1'b0;
        fetch_enable = 1'b0;
        pc = '0;
        cache_flush = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data = '0;
        @(negedge clk);
        chk("rst_rdy", 32'(instruction_ready), 0);
        chk("rst_mv", 32'(mem_read_valid), 0);
        chk("rst_addr", 32'(mem_read_address), 0);
        chk("rst_instr", 32'(instruction), 0);
        reset = 1'b1;
        @(negedge clk);

        idle_cycle(1'b0, 1'b1);
        fetch(8'h05, 3, 0);
        fetch(8'h05, 0, 0);
        fetch(8'h09, 1, 0);
        fetch(8'h05, 2, 0);
        fetch(8'h05, 0, 0);
        idle_cycle(1'b0, 1'b1);
        fetch(8'h05, 2, 3);
        fetch(8'h10, 1, 0);
        fetch(8'h05, 0, 0);
        fetch(8'h33, 2, 1);
        fetch(8'h33, 0, 0);
        fetch(8'h05, 1, 0);
        fetch(8'h05, 0, 2);
        fetch(8'h05, 0, 0);

        fetch_enable = 1'b1;
        pc = 8'h22;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_mv", 32'(mem_read_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_mv", 32'(mem_read_valid), 0);
        chk("arst_rdy", 32'(instruction_ready), 0);
        chk("arst_instr", 32'(instruction), 0);
        fetch_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_flush();
        m_instr = '0;
        idle_cycle(1'b1, 1'b0);
        fetch(8'h05, 1, 0);
        fetch(8'h22, 0, 0);

        for (int t = 0; t < 250; t++) begin
            logic [AW-1:0] p;
            int r;
            int mode;
            p = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 11)) : AW'($urandom);
            r = int'($urandom_range(0, 9));
            mode = (r < 5) ? 0 : r - 5;
            fetch(p, int'($urandom_range(0, 4)), mode);
            if ($urandom_range(0, 3) == 0)
                idle_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Fetch stage that sits directly upstream of the per-core warp scheduler.
- Responds to the scheduler's fetch_enable by reading the instruction at the current warp's PC and returning it with a one-cycle instruction_ready.
- Fronts program memory with a small direct-mapped instruction cache, so repeated PCs across warps hit locally.
- Misses are filled over a valid/ready read handshake to the program-memory controller.

Parameters:
- PROGRAM_ADDR_BITS, 8, PC/program-memory address width.
- PROGRAM_DATA_BITS, 16, instruction width.
- CACHE_ENTRIES, 4, number of direct-mapped lines, one instruction per line, power of two >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_enable  input  1  level request from scheduler; high while scheduler is in FETCHING.
- pc  input  PROGRAM_ADDR_BITS  PC of the scheduler's current warp; may change while fetch_enable is high.
- cache_flush  input  1  one-cycle pulse; invalidates all lines.
- instruction  output  PROGRAM_DATA_BITS  fetched instruction; held stable until the next READY.
- instruction_ready  output  1  high for exactly one cycle when instruction is valid for the latched PC.
- mem_read_valid  output  1  program-memory read request.
- mem_read_address  output  PROGRAM_ADDR_BITS  request address; stable while mem_read_valid is high.
- mem_read_ready  input  1  memory response strobe; mem_read_data is valid in the same cycle.
- mem_read_data  input  PROGRAM_DATA_BITS  response data.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - instruction, instruction_ready, mem_read_valid and mem_read_address = 0.
  - All valid bits = 0; latched PC = 0.
  - Mid-transaction reset abandons any outstanding request; a mem_read_ready arriving after reset is ignored.
- Cache organisation: index = pc[log2(CACHE_ENTRIES)-1:0]; tag = remaining upper PC bits; one valid bit per line.
- IDLE: if fetch_enable, latch pc into req_pc and go to LOOKUP.
- LOOKUP (one cycle):
  - If !fetch_enable or pc != req_pc (scheduler switched warp), go to IDLE without an output.
  - Else on hit: instruction <= line data; go to READY.
  - Else on miss: mem_read_valid <= 1, mem_read_address <= req_pc; go to WAIT.
- WAIT:
  - mem_read_valid stays high until the cycle mem_read_ready is sampled high; it drops the next cycle.
  - On mem_read_ready, write the line (data, tag, valid=1) at index(req_pc).
  - Same cycle: if fetch_enable and pc == req_pc, instruction <= mem_read_data and go to READY; otherwise go to IDLE (the fill is still written).
- READY:
  - instruction_ready = 1 for this cycle only; then go to IDLE.
  - If fetch_enable is still high next cycle, a new fetch starts from IDLE.
- Latency:
  - Hit: fetch_enable sampled at cycle N -> instruction_ready at N+2.
  - Miss: mem_read_valid rises at N+2; instruction_ready in the cycle after the mem_read_ready cycle.
- Only one outstanding memory request at a time. mem_read_ready seen outside WAIT is ignored.
- cache_flush:
  - Clears all valid bits next edge, in any state.
  - If it coincides with a WAIT fill, flush wins: the line is not written, but the data is still forwarded to READY if the PC matches.
  - A LOOKUP in the same cycle as the flush uses the pre-flush valid bits.
- instruction is only updated on transitions into READY.

Test Plan:
- Cold miss: reset, flush, fetch_enable=1, pc=0x05; memory returns 0x3A7F with mem_read_ready 3 cycles after request -> mem_read_valid high with address 0x05 until the ready cycle; instruction_ready one cycle later with instruction=0x3A7F.
- Hit: repeat fetch of pc=0x05 -> no mem_read_valid; instruction_ready at N+2 with 0x3A7F.
- Conflict eviction (CACHE_ENTRIES=4): fetch 0x05 then 0x09, both index 1 -> both miss. Refetch 0x05 -> misses again.
- Warp switch mid-miss: pc changes 0x05 -> 0x10 while in WAIT -> no instruction_ready for 0x05; line 0x05 filled; new fetch for 0x10 starts from IDLE; subsequent 0x05 fetch hits.
- Flush coincident with fill: cache_flush in the mem_read_ready cycle -> instruction_ready with correct data; next fetch of the same PC misses.
- Async reset during WAIT: reset low mid-request -> mem_read_valid and instruction_ready drop immediately; a late mem_read_ready is ignored; all lines are invalid afterwards.
